fft_frame_ctrl: RTL and testbench

//  Sequences the streaming FFT core for one audio channel. Packs codec samples into N-point sink

---
 rtl/fft_frame_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
// Frame sequencer that sits between one audio codec channel, a streaming FFT
// core and the Nios PIO read-back path.
//   - Collects codec samples into N-point sink frames and marks the first
//     sample with sop and the last with eop.
//   - Stores the N output bins of the FFT in an internal N x (2*OW) RAM.
//   - Raises fft_start once a frame of bins is ready, then serves
//     RAM[rd_addr] to Nios until Nios signals that it has consumed the frame.
// Ports
//   clk, reset_n                   clock, asynchronous active-low reset
//   enable                         run request
//   smp_valid, smp_data            codec sample strobe and signed data
//   sink_valid/sop/eop/real/ready  FFT sink handshake
//   src_valid/sop/eop/real/imag    FFT source stream
//   src_ready                      back-pressure to the FFT source
//   rd_addr, rd_done               Nios bin index and frame-consumed flag
//   fft_real, fft_img              registered RAM[rd_addr] contents
//   fft_start                      frame of bins available to Nios
//   fft_cnt                        completed-frame counter (wraps)
//   ovf, err                       sticky sample-overrun and short-frame flags
module fft_frame_ctrl #(
  parameter int N     = 1024,
  parameter int LOG2N = 10,
  parameter int DW    = 16,
  parameter int OW    = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             smp_valid,
  input  logic [DW-1:0]    smp_data,
  output logic             sink_valid,
  output logic             sink_sop,
  output logic             sink_eop,
  output logic [DW-1:0]    sink_real,
  input  logic             sink_ready,
  input  logic             src_valid,
  input  logic             src_sop,
  input  logic             src_eop,
  input  logic [OW-1:0]    src_real,
  input  logic [OW-1:0]    src_imag,
  output logic             src_ready,
  input  logic [LOG2N-1:0] rd_addr,
  input  logic             rd_done,
  output logic [OW-1:0]    fft_real,
  output logic [OW-1:0]    fft_img,
  output logic             fft_start,
  output logic [LOG2N-1:0] fft_cnt,
  output logic             ovf,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WAIT,
    CAPTURE,
    READY
  } state_t;

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  state_t state;
  state_t next_state;

  logic             hold_valid;
  logic [DW-1:0]    hold_data;
  logic [LOG2N-1:0] smp_idx;
  logic [LOG2N-1:0] bin_idx;
  logic             rd_done_q;

  logic [2*OW-1:0]  bin_ram [N];

  logic             accept;
  logic             fill_done;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr;
  logic             cap_last;
  logic             cap_end;
  logic             rd_rise;

  // Handshake and frame-boundary decodes shared by the FSM and datapath.
  // A bin carrying src_sop always lands at index 0, both when it opens a
  // frame in WAIT and when it restarts a frame during CAPTURE.
  always_comb begin
    accept    = (state == FILL) && hold_valid && sink_ready;
    fill_done = accept && (smp_idx == LAST_IDX);
    wr_en     = src_valid && (((state == WAIT) && src_sop) || (state == CAPTURE));
    wr_addr   = ((state == WAIT) || src_sop) ? '0 : bin_idx;
    cap_last  = wr_en && (wr_addr == LAST_IDX);
    cap_end   = wr_en && (cap_last || src_eop);
    rd_rise   = rd_done && !rd_done_q;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. enable is only looked at when starting from IDLE and
  // when Nios releases a finished frame, so a frame in flight always completes.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (enable)    next_state = FILL;
      FILL:    if (fill_done) next_state = WAIT;
      WAIT: begin
        if (cap_end)     next_state = READY;
        else if (wr_en)  next_state = CAPTURE;
      end
      CAPTURE: if (cap_end)   next_state = READY;
      READY:   if (rd_rise)   next_state = enable ? FILL : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode. sink_sop/eop follow the index of the sample currently
  // held, so they line up with whatever the FFT sink sees on sink_real.
  always_comb begin
    sink_valid = (state == FILL) && hold_valid;
    sink_sop   = sink_valid && (smp_idx == '0);
    sink_eop   = sink_valid && (smp_idx == LAST_IDX);
    src_ready  = (state == WAIT) || (state == CAPTURE);
    fft_start  = (state == READY);
  end

  assign sink_real = hold_data;

  // Single-entry sample holding register. Outside FILL the register is empty
  // and the index is parked at 0, so every FILL starts a fresh frame. A new
  // sample arriving while the held one is still unaccepted replaces it and
  // flags an overrun; one arriving in the same cycle as an accept simply
  // takes the freed slot. Anything arriving with the final accept belongs to
  // no frame and is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      smp_idx    <= '0;
      ovf        <= 1'b0;
    end else if (state != FILL) begin
      hold_valid <= 1'b0;
      smp_idx    <= '0;
    end else begin
      if (accept) begin
        smp_idx <= smp_idx + 1'b1;
      end
      if (fill_done) begin
        hold_valid <= 1'b0;
      end else if (smp_valid) begin
        hold_valid <= 1'b1;
        hold_data  <= smp_data;
        if (hold_valid && !accept) begin
          ovf <= 1'b1;
        end
      end else if (accept) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Bin index tracking and short-frame detection. An eop before the last
  // index ends the frame early; the bins written so far stay valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_idx <= '0;
      err     <= 1'b0;
    end else if (wr_en) begin
      bin_idx <= wr_addr + 1'b1;
      if (src_eop && !cap_last) begin
        err <= 1'b1;
      end
    end
  end

  // Bin RAM write port. The RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bin_ram[wr_addr] <= {src_real, src_imag};
    end
  end

  // Nios read-back and frame bookkeeping. The read port refreshes every
  // cycle in READY and freezes otherwise, so Nios keeps seeing the last bin.
  // Only a rising edge of rd_done in READY closes the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fft_real  <= '0;
      fft_img   <= '0;
      fft_cnt   <= '0;
      rd_done_q <= 1'b0;
    end else begin
      rd_done_q <= rd_done;
      if (state == READY) begin
        {fft_real, fft_img} <= bin_ram[rd_addr];
        if (rd_rise) begin
          fft_cnt <= fft_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl
// Scoreboard bench for fft_frame_ctrl, built with a small frame size so that
// a full fft_cnt wrap fits in a short run. Stimulus pushes the expected sink
// samples and expected read-back bins into queues; two monitors pop and
// compare whenever the DUT presents a sink transfer or a read result.
module tb_fft_frame_ctrl;

  localparam int N     = 32;
  localparam int LOG2N = 5;
  localparam int DW    = 16;
  localparam int OW    = 24;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } sink_exp_t;

  typedef struct packed {
    logic [OW-1:0] re;
    logic [OW-1:0] im;
  } bin_exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             smp_valid = 1'b0;
  logic [DW-1:0]    smp_data = '0;
  logic             sink_valid;
  logic             sink_sop;
  logic             sink_eop;
  logic [DW-1:0]    sink_real;
  logic             sink_ready = 1'b1;
  logic             src_valid = 1'b0;
  logic             src_sop = 1'b0;
  logic             src_eop = 1'b0;
  logic [OW-1:0]    src_real = '0;
  logic [OW-1:0]    src_imag = '0;
  logic             src_ready;
  logic [LOG2N-1:0] rd_addr = '0;
  logic             rd_done = 1'b0;
  logic [OW-1:0]    fft_real;
  logic [OW-1:0]    fft_img;
  logic             fft_start;
  logic [LOG2N-1:0] fft_cnt;
  logic             ovf;
  logic             err;

  int checks = 0;
  int failures = 0;

  sink_exp_t sink_q[$];
  bin_exp_t  rd_q[$];
  logic      rd_req = 1'b0;
  logic      rd_pend = 1'b0;

  fft_frame_ctrl #(
    .N(N), .LOG2N(LOG2N), .DW(DW), .OW(OW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .smp_valid(smp_valid),
    .smp_data(smp_data),
    .sink_valid(sink_valid),
    .sink_sop(sink_sop),
    .sink_eop(sink_eop),
    .sink_real(sink_real),
    .sink_ready(sink_ready),
    .src_valid(src_valid),
    .src_sop(src_sop),
    .src_eop(src_eop),
    .src_real(src_real),
    .src_imag(src_imag),
    .src_ready(src_ready),
    .rd_addr(rd_addr),
    .rd_done(rd_done),
    .fft_real(fft_real),
    .fft_img(fft_img),
    .fft_start(fft_start),
    .fft_cnt(fft_cnt),
    .ovf(ovf),
    .err(err)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sink monitor: every accepted sample must match the head of sink_q.
  always @(negedge clk) begin
    sink_exp_t e;
    if (reset_n && sink_valid && sink_ready) begin
      if (sink_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL sink_unexpected: got data 0x%0h, expected no transfer at %0t",
                 sink_real, $time);
      end else begin
        e = sink_q.pop_front();
        checkOutput("sink_real", 32'(sink_real), 32'(e.data));
        checkOutput("sink_sop", 32'(sink_sop), 32'(e.sop));
        checkOutput("sink_eop", 32'(sink_eop), 32'(e.eop));
      end
    end
  end

  // Read monitor: a read issued in one cycle is compared one cycle later.
  always @(negedge clk) begin
    bin_exp_t b;
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL rd_unexpected: got 0x%0h, expected queued read at %0t", fft_real, $time);
      end else begin
        b = rd_q.pop_front();
        checkOutput("fft_real", 32'(fft_real), 32'(b.re));
        checkOutput("fft_img", 32'(fft_img), 32'(b.im));
      end
    end
    rd_pend = rd_req;
  end

  // Drive count samples starting at frame index start_idx, one per cycle,
  // with sink_ready high so each is accepted one cycle after it is loaded.
  task automatic applyStimulus(input int count, input int start_idx, input int base);
    sink_exp_t e;
    for (int i = 0; i < count; i++) begin
      smp_valid = 1'b1;
      smp_data  = DW'(base + 7 * i);
      e.data = smp_data;
      e.sop  = ((start_idx + i) == 0);
      e.eop  = ((start_idx + i) == N - 1);
      sink_q.push_back(e);
      tick();
    end
    smp_valid = 1'b0;
  endtask

  task automatic wait_src_ready();
    int budget = 50;
    while (!src_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!src_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL src_ready_timeout: got 0, expected 1 within 50 cycles at %0t", $time);
    end
  endtask

  // FFT source model: bin k carries real=k+off, imag=-(k+off).
  task automatic send_bins(input int count, input int off, input bit with_eop);
    wait_src_ready();
    for (int k = 0; k < count; k++) begin
      src_valid = 1'b1;
      src_sop   = (k == 0);
      src_eop   = with_eop && (k == count - 1);
      src_real  = OW'(k + off);
      src_imag  = OW'(0 - (k + off));
      tick();
    end
    src_valid = 1'b0;
    src_sop   = 1'b0;
    src_eop   = 1'b0;
  endtask

  task automatic wait_start();
    int budget = 20;
    while (!fft_start && budget > 0) begin
      tick();
      budget--;
    end
    checkOutput("fft_start_up", 32'(fft_start), 32'd1);
  endtask

  task automatic issue_read(input int addr, input int value);
    bin_exp_t b;
    rd_addr = LOG2N'(addr);
    rd_req  = 1'b1;
    b.re = OW'(value);
    b.im = OW'(0 - value);
    rd_q.push_back(b);
    tick();
    rd_req = 1'b0;
    tick();
  endtask

  task automatic pulse_rd_done();
    rd_done = 1'b1;
    tick();
    tick();
    tick();
    rd_done = 1'b0;
    tick();
  endtask

  // Watchdog so a stuck DUT still reaches the summary.
  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 500000 ns");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state.
    tick();
    tick();
    checkOutput("rst_sink_valid", 32'(sink_valid), 32'd0);
    checkOutput("rst_src_ready", 32'(src_ready), 32'd0);
    checkOutput("rst_fft_start", 32'(fft_start), 32'd0);
    checkOutput("rst_fft_cnt", 32'(fft_cnt), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_fft_real", 32'(fft_real), 32'd0);
    checkOutput("rst_fft_img", 32'(fft_img), 32'd0);
    reset_n = 1'b1;
    tick();

    // Frame 0: clean full frame, bins real=k, imag=-k.
    $display("[TB] frame 0: full frame");
    enable = 1'b1;
    tick();
    tick();
    applyStimulus(N, 0, -50);
    tick();
    checkOutput("wait_src_ready", 32'(src_ready), 32'd1);
    checkOutput("wait_sink_valid", 32'(sink_valid), 32'd0);
    send_bins(N, 0, 1'b1);
    wait_start();
    checkOutput("f0_err", 32'(err), 32'd0);
    checkOutput("f0_ovf", 32'(ovf), 32'd0);
    issue_read(5, 5);
    issue_read(0, 0);
    issue_read(N - 1, N - 1);
    pulse_rd_done();
    checkOutput("f0_fft_start_down", 32'(fft_start), 32'd0);
    checkOutput("f0_fft_cnt", 32'(fft_cnt), 32'd1);

    // Frame 1: overrun on the first sample, then a short frame.
    $display("[TB] frame 1: overrun and short frame");
    sink_ready = 1'b0;
    smp_valid  = 1'b1;
    smp_data   = 16'h1111;
    tick();
    smp_data   = 16'h2222;
    begin
      sink_exp_t e;
      e.data = 16'h2222;
      e.sop  = 1'b1;
      e.eop  = 1'b0;
      sink_q.push_back(e);
    end
    tick();
    smp_valid  = 1'b0;
    sink_ready = 1'b1;
    tick();
    checkOutput("f1_ovf", 32'(ovf), 32'd1);
    applyStimulus(N - 1, 1, 300);
    send_bins(N / 2, 1000, 1'b1);
    wait_start();
    checkOutput("f1_err", 32'(err), 32'd1);
    issue_read(5, 1005);
    issue_read(N / 2 - 1, 1000 + N / 2 - 1);
    issue_read(N / 2, N / 2);
    pulse_rd_done();
    checkOutput("f1_fft_cnt", 32'(fft_cnt), 32'd2);
    pulse_rd_done();
    checkOutput("f1_rd_done_outside_ready", 32'(fft_cnt), 32'd2);

    // Frames 2..N-1: run the counter round to a wrap.
    $display("[TB] frames 2..%0d: counter wrap", N - 1);
    for (int f = 2; f < N; f++) begin
      if (f == N - 1) begin
        applyStimulus(N / 2, 0, 11 * f);
        enable = 1'b0;
        applyStimulus(N / 2, N / 2, 11 * f + 7 * (N / 2));
      end else begin
        applyStimulus(N, 0, 11 * f);
      end
      if (f == 2) begin
        rd_done = 1'b1;
      end
      send_bins(N, 100 * f, 1'b1);
      wait_start();
      if (f == 2) begin
        tick();
        tick();
        tick();
        checkOutput("held_rd_done_start", 32'(fft_start), 32'd1);
        checkOutput("held_rd_done_cnt", 32'(fft_cnt), 32'd2);
        rd_done = 1'b0;
        tick();
      end
      issue_read(f, 100 * f + f);
      pulse_rd_done();
    end
    checkOutput("wrap_fft_cnt", 32'(fft_cnt), 32'd0);
    checkOutput("wrap_fft_start", 32'(fft_start), 32'd0);
    checkOutput("sticky_err", 32'(err), 32'd1);
    checkOutput("sticky_ovf", 32'(ovf), 32'd1);

    // IDLE with enable low: samples are dropped, source is not accepted.
    smp_valid = 1'b1;
    smp_data  = 16'h7777;
    tick();
    tick();
    smp_valid = 1'b0;
    checkOutput("idle_sink_valid", 32'(sink_valid), 32'd0);
    checkOutput("idle_src_ready", 32'(src_ready), 32'd0);

    // Reset in the middle of CAPTURE, then a clean restart.
    $display("[TB] reset during capture");
    enable = 1'b1;
    tick();
    tick();
    applyStimulus(N, 0, 900);
    send_bins(N / 2, 5000, 1'b0);
    checkOutput("cap_src_ready", 32'(src_ready), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_src_ready", 32'(src_ready), 32'd0);
    checkOutput("mid_rst_sink_valid", 32'(sink_valid), 32'd0);
    checkOutput("mid_rst_fft_start", 32'(fft_start), 32'd0);
    checkOutput("mid_rst_fft_cnt", 32'(fft_cnt), 32'd0);
    checkOutput("mid_rst_ovf", 32'(ovf), 32'd0);
    checkOutput("mid_rst_err", 32'(err), 32'd0);
    checkOutput("mid_rst_fft_real", 32'(fft_real), 32'd0);
    checkOutput("mid_rst_fft_img", 32'(fft_img), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    applyStimulus(N, 0, 1200);
    send_bins(N, 6000, 1'b1);
    wait_start();
    checkOutput("restart_err", 32'(err), 32'd0);
    checkOutput("restart_ovf", 32'(ovf), 32'd0);
    issue_read(N - 1, 6000 + N - 1);
    issue_read(N / 2, 6000 + N / 2);
    pulse_rd_done();
    checkOutput("restart_fft_cnt", 32'(fft_cnt), 32'd1);

    tick();
    checkOutput("sink_q_drained", 32'(sink_q.size()), 32'd0);
    checkOutput("rd_q_drained", 32'(rd_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
